mmio_ports: RTL

MMIO_PORTS -- requirements
Module: mmio_ports

---
 rtl/mmio_pkg.sv | 32 +++
 rtl/mmio_chan_detect.sv | 46 ++++
 rtl/mmio_ports.sv | 108 ++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared register-map helpers for the memory-mapped I/O port block.
// Offsets are relative to the window base and are derived from the channel count.
package mmio_pkg;

  // STATUS, MASK and ACK follow the OUT and IN register groups.
  localparam int N_CTRL_REGS = 3;

  function automatic int win_size(input int nch);
    return 2 * nch + N_CTRL_REGS;
  endfunction

  function automatic int off_in(input int nch);
    return nch;
  endfunction

  function automatic int off_status(input int nch);
    return 2 * nch;
  endfunction

  function automatic int off_mask(input int nch);
    return 2 * nch + 1;
  endfunction

  function automatic int off_ack(input int nch);
    return 2 * nch + 2;
  endfunction

  function automatic int default_io_base(input int aw, input int nch);
    return (2 ** aw) - win_size(nch);
  endfunction

endpackage

// File: rtl/mmio_chan_detect.sv
// One input channel: two-flop synchronizer, previous-value register and
// sticky pending/overrun flags raised on a change of the synchronized value.
module mmio_chan_detect #(
  parameter int NBITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] din,
  input  logic             detect_en,
  input  logic             ack,
  output logic [NBITS-1:0] sync_val,
  output logic             pending,
  output logic             overrun
);

  logic [NBITS-1:0] sync1_q;
  logic [NBITS-1:0] sync2_q;
  logic [NBITS-1:0] prev_q;
  logic             change;

  assign change   = detect_en && (sync2_q != prev_q);
  assign sync_val = sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // A new event beats a simultaneous acknowledge; overrun is left alone then.
      if (change) begin
        pending <= 1'b1;
        if (!ack) overrun <= overrun | pending;
      end else if (ack) begin
        pending <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mmio_ports.sv
// Memory-mapped output/input port block with change-detect interrupt.
// Address decode, register file, read mux and interrupt live here.
module mmio_ports
  import mmio_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int NCH     = 4,
  parameter int AW      = NBITS - 2,
  parameter int IO_BASE = default_io_base(AW, NCH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [AW-1:0]              address,
  input  logic [NBITS-1:0]           wdata,
  input  logic                       wren,
  output logic                       io_sel,
  output logic [NBITS-1:0]           rdata,
  input  logic [NCH-1:0][NBITS-1:0]  entrada,
  output logic [NCH-1:0][NBITS-1:0]  saida,
  output logic                       interrupt
);

  localparam int          WIN        = win_size(NCH);
  localparam logic [AW:0] BASE_X     = (AW+1)'(IO_BASE);
  localparam logic [AW:0] END_X      = (AW+1)'(IO_BASE + WIN);
  localparam logic [AW:0] OFF_IN     = (AW+1)'(off_in(NCH));
  localparam logic [AW:0] OFF_STATUS = (AW+1)'(off_status(NCH));
  localparam logic [AW:0] OFF_MASK   = (AW+1)'(off_mask(NCH));
  localparam logic [AW:0] OFF_ACK    = (AW+1)'(off_ack(NCH));

  logic [AW:0]                 addr_x;
  logic [AW:0]                 off;
  logic                        hit;
  logic                        wr;
  logic [NCH-1:0][NBITS-1:0]   out_q;
  logic [NCH-1:0]              mask_q;
  logic [1:0]                  warm_q;
  logic                        detect_en;
  logic [NCH-1:0][NBITS-1:0]   in_sync;
  logic [NCH-1:0]              pending;
  logic [NCH-1:0]              overrun;
  logic [NCH-1:0]              ack_clr;
  logic [NBITS-1:0]            rd_next;

  // One extra address bit so the window end may equal 2**AW.
  assign addr_x = {1'b0, address};
  assign hit    = (addr_x >= BASE_X) && (addr_x < END_X);
  assign off    = addr_x - BASE_X;
  assign wr     = wren && hit;

  assign detect_en = (warm_q == 2'd3);
  assign ack_clr   = (wr && (off == OFF_ACK)) ? wdata[NCH-1:0] : '0;
  assign saida     = out_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      mask_q <= '0;
      warm_q <= 2'd0;
    end else begin
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      for (int ch = 0; ch < NCH; ch++) begin
        if (wr && (off == (AW+1)'(ch))) out_q[ch] <= wdata;
      end
      if (wr && (off == OFF_MASK)) mask_q <= wdata[NCH-1:0];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    mmio_chan_detect #(.NBITS(NBITS)) u_chan (
      .clock     (clock),
      .reset     (reset),
      .din       (entrada[g]),
      .detect_en (detect_en),
      .ack       (ack_clr[g]),
      .sync_val  (in_sync[g]),
      .pending   (pending[g]),
      .overrun   (overrun[g])
    );
  end

  always_comb begin
    rd_next = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (off == (AW+1)'(ch))            rd_next = out_q[ch];
      if (off == OFF_IN + (AW+1)'(ch))   rd_next = in_sync[ch];
    end
    if (off == OFF_STATUS) begin
      rd_next[NCH-1:0]     = pending;
      rd_next[2*NCH-1:NCH] = overrun;
    end
    if (off == OFF_MASK) rd_next[NCH-1:0] = mask_q;
    if (!hit) rd_next = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_sel    <= 1'b0;
      rdata     <= '0;
      interrupt <= 1'b0;
    end else begin
      io_sel    <= hit;
      rdata     <= rd_next;
      interrupt <= |(pending & mask_q);
    end
  end

endmodule
